vga_timing_ctrl: RTL
====================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The block SHALL have parameter H_SYNC, default 96: hsync pulse width in pixels.
REQ-002 The block SHALL have parameter H_BP, default 48: horizontal back porch in pixels.
REQ-003 The block SHALL have parameter H_ACT, default 640: active pixels per line; it is a multiple of 8.
REQ-004 The block SHALL have parameter H_FP, default 16: horizontal front porch in pixels.
REQ-005 The block SHALL have parameters V_SYNC=2, V_BP=33, V_ACT=480, V_FP=10: the vertical equivalents, in lines.
REQ-006 The block SHALL have parameter DATA_W, default 16: RGB565 pixel width.
REQ-007 The block SHALL have parameter CNT_W, default 11: counter and coordinate width.
REQ-008 The block SHALL have parameter REQ_LEAD, default 1: pix_data_req lead over de in cycles, legal range 0..H_BP.
REQ-009 The block SHALL have parameter SYNC_POL, default 1: sync active level (1 = active-high).
REQ-010 The block SHALL have port vga_clk, input, 1: pixel clock, the only clock.
REQ-011 The block SHALL have port sys_rst_n, input, 1: synchronous active-low reset.
REQ-012 The block SHALL have port pat_en, input, 1: selects the internal colour-bar pattern instead of pix_data.
REQ-013 The block SHALL have port pix_data, input, DATA_W: pixel returned one REQ_LEAD after the request.
REQ-014 The block SHALL have ports pix_x and pix_y, output, CNT_W each: coordinates of the requested pixel.
REQ-015 The block SHALL have port pix_data_req, output, 1: pixel request.
REQ-016 The block SHALL have ports hsync, vsync, de, output, 1 each: sync pulses and display enable.
REQ-017 The block SHALL have ports frame_start and line_start, output, 1 each: single-cycle markers.
REQ-018 The block SHALL have port rgb, output, DATA_W: pixel output to the DAC.

Function
REQ-019 cnt_h SHALL count 0..H_TOT-1, where H_TOT = H_SYNC+H_BP+H_ACT+H_FP, and wrap to 0.
REQ-020 cnt_v SHALL increment when cnt_h == H_TOT-1 and wrap to 0 after V_TOT-1.
REQ-021 hsync SHALL equal SYNC_POL when cnt_h < H_SYNC, and ~SYNC_POL otherwise.
REQ-022 vsync SHALL equal SYNC_POL when cnt_v < V_SYNC, and ~SYNC_POL otherwise.
REQ-023 de SHALL be 1 iff cnt_h is in [HS, HS+H_ACT-1] and cnt_v is in [VS, VS+V_ACT-1], where HS = H_SYNC+H_BP and VS = V_SYNC+V_BP.
REQ-024 pix_data_req SHALL equal de's horizontal window shifted REQ_LEAD cycles earlier, within the same line and the same vertical window.
REQ-025 pix_x SHALL equal cnt_h-(HS-REQ_LEAD) while pix_data_req is 1, and all-ones otherwise.
REQ-026 pix_y SHALL equal cnt_v-VS while pix_data_req is 1, and all-ones otherwise.
REQ-027 hsync, vsync, de, pix_data_req, pix_x, pix_y, frame_start and line_start SHALL be combinational decodes of the registered counters, so they have zero latency from the counters.
REQ-028 frame_start SHALL be 1 only when cnt_h==0 and cnt_v==0; line_start SHALL be 1 only when cnt_h==0.
REQ-029 rgb SHALL equal pix_data when de is 1 and the registered pattern select is 0; it SHALL be the bar colour when de is 1 and the select is 1; it SHALL be 0 when de is 0.
REQ-030 The pattern select SHALL be registered from pat_en only in the cycle frame_start is 1, so a pat_en change mid-frame takes effect at the next frame.
REQ-031 The pattern SHALL be 8 vertical bars of H_ACT/8 pixels each, in this order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-032 The bar index SHALL reset to 0 at the start of each active line and advance via a pixel counter, with no divider.
REQ-033 With REQ_LEAD=0, pix_data_req SHALL equal de.

Reset
REQ-034 While sys_rst_n is 0 at a vga_clk edge, cnt_h, cnt_v, the pattern select and the bar counters SHALL go to 0.
REQ-035 Applying reset mid-line or mid-frame SHALL restart timing at cnt_h=0, cnt_v=0, and frame_start SHALL assert in the first cycle after release.
REQ-036 During reset, outputs SHALL show the decode of the zeroed counters: hsync=vsync=SYNC_POL, de=0, pix_data_req=0, pix_x=pix_y=all-ones, rgb=0.

Structure
REQ-037 Package vga_timing_pkg SHALL hold the default 640x480@60 constants and the 8-entry RGB565 bar-colour table.
REQ-038 The bar generator SHALL be one sub-module, vga_bar_gen, with inputs de, line_start, pixel advance and select, and output the colour.
REQ-039 The top level SHALL contain the counters, the sync/de/request decode and the rgb mux.

Verification
REQ-040 Bench: reset held 10 cycles, then released -> frame_start=1 in the first cycle, hsync=1, rgb=0, pix_x=11'h7FF.
REQ-041 Bench: defaults -> hsync high for 96 of every 800 cycles; vsync high for 1600 of every 420000 cycles.
REQ-042 Bench: REQ_LEAD=1, constant pix_data=16'hFFFF -> on line cnt_v=35, pix_data_req is 1 at cnt_h=143 with pix_x=0; de is 1 at cnt_h 144..783; rgb=FFFF only while de is 1.
REQ-043 Bench: REQ_LEAD=0 -> pix_data_req == de on every cycle of a full frame.
REQ-044 Bench: pat_en raised at cnt_v=100 -> rgb follows pix_data until the next frame_start; then line 35 shows FFFF at cnt_h 144..223, FFE0 at 224..303, …, 0000 at 704..783.
REQ-045 Bench: sys_rst_n pulsed low at cnt_h=500, cnt_v=200 -> after release, cnt_h=0 and cnt_v=0, and the next frame_start occurs 420000 cycles later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the RGB565 colour-bar table.
package vga_timing_pkg;

  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_ACT_DEF    = 640;
  localparam int H_FP_DEF     = 16;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_ACT_DEF    = 480;
  localparam int V_FP_DEF     = 10;
  localparam int DATA_W_DEF   = 16;
  localparam int CNT_W_DEF    = 11;
  localparam int REQ_LEAD_DEF = 1;
  localparam int SYNC_POL_DEF = 1;

  // Bar 0 sits in the least significant slot, so BAR_TABLE[i] is bar i from the left.
  localparam logic [7:0][15:0] BAR_TABLE = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_bar_gen.sv
// Eight-bar colour generator: tracks the bar position with a pixel counter, no divider.
module vga_bar_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de,
  input  logic              line_start,
  input  logic              pix_adv,
  input  logic              sel,
  output logic [DATA_W-1:0] colour
);

  localparam int BAR_W = H_ACT / 8;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] bar_pix;
  logic [2:0]       bar_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (line_start) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (de && pix_adv) begin
      if (bar_pix == BAR_LAST) begin
        bar_pix <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pix <= bar_pix + 1'b1;
      end
    end
  end

  assign colour = sel ? DATA_W'(bar_colour(bar_idx)) : '0;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: h/v counters, zero-latency sync/de/request decode and rgb mux.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACT    = H_ACT_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACT    = V_ACT_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int REQ_LEAD = REQ_LEAD_DEF,
  parameter int SYNC_POL = SYNC_POL_DEF
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              pat_en,
  input  logic [DATA_W-1:0] pix_data,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              pix_data_req,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start,
  output logic              line_start,
  output logic [DATA_W-1:0] rgb
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HS    = H_SYNC + H_BP;
  localparam int VS    = V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] DE_BEG   = CNT_W'(HS);
  localparam logic [CNT_W-1:0] DE_END   = CNT_W'(HS + H_ACT);
  localparam logic [CNT_W-1:0] RQ_BEG   = CNT_W'(HS - REQ_LEAD);
  localparam logic [CNT_W-1:0] RQ_END   = CNT_W'(HS + H_ACT - REQ_LEAD);
  localparam logic [CNT_W-1:0] V_BEG    = CNT_W'(VS);
  localparam logic [CNT_W-1:0] V_END    = CNT_W'(VS + V_ACT);
  localparam logic             POL      = (SYNC_POL != 0);

  logic [CNT_W-1:0]  cnt_h;
  logic [CNT_W-1:0]  cnt_v;
  logic              sel;
  logic              v_win;
  logic [DATA_W-1:0] bar_rgb;

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
    end else begin
      cnt_h <= cnt_h + 1'b1;
    end
  end

  // Pattern select only changes on frame boundaries so a frame is never split.
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      sel <= 1'b0;
    end else if (frame_start) begin
      sel <= pat_en;
    end
  end

  always_comb begin
    v_win        = (cnt_v >= V_BEG) && (cnt_v < V_END);
    hsync        = (cnt_h < H_SYNC_C) ? POL : ~POL;
    vsync        = (cnt_v < V_SYNC_C) ? POL : ~POL;
    de           = v_win && (cnt_h >= DE_BEG) && (cnt_h < DE_END);
    pix_data_req = v_win && (cnt_h >= RQ_BEG) && (cnt_h < RQ_END);
    pix_x        = pix_data_req ? cnt_h - RQ_BEG : '1;
    pix_y        = pix_data_req ? cnt_v - V_BEG : '1;
    line_start   = (cnt_h == '0);
    frame_start  = (cnt_h == '0) && (cnt_v == '0);
  end

  always_comb begin
    rgb = '0;
    if (de) begin
      rgb = sel ? bar_rgb : pix_data;
    end
  end

  vga_bar_gen #(
    .H_ACT  (H_ACT),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_bar_gen (
    .clk        (vga_clk),
    .rst_n      (sys_rst_n),
    .de         (de),
    .line_start (line_start),
    .pix_adv    (1'b1),
    .sel        (sel),
    .colour     (bar_rgb)
  );

endmodule
